ex_mem_stage: RTL

- Consumes the ALU Result and Z/N/V/C flags of the execute stage.
- Resolves branches and jumps from the flags and generates the PC redirect (PCSrcE/PCTargetE) back to fetch.
- Registers the surviving execute-stage payload into the memory-stage pipeline register, with stall and flush.
- Keeps two wrap-around performance counters: branches retired out of EX, and redirects taken.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/branch_cond.sv | 28 ++
 rtl/ex_mem_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 encodings used by the execute/memory boundary logic.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_branch_e;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from the SUB flags of the ALU (rs1 - rs2).
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    input  logic       c,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = z;
            F3_BNE:  cond = ~z;
            // Signed less-than is the sign of the true difference, i.e. N corrected by V.
            F3_BLT:  cond = n ^ v;
            F3_BGE:  cond = ~(n ^ v);
            // Carry set on SUB means no borrow, i.e. rs1 >= rs2 unsigned.
            F3_BLTU: cond = ~c;
            F3_BGEU: cond = c;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: branch/jump resolution, PC redirect, M pipeline register
// with stall/flush, and branch/redirect performance counters.
module ex_mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidE,
    input  logic [XLEN-1:0]  ALUResultE,
    input  logic             ZE,
    input  logic             NE,
    input  logic             VE,
    input  logic             CE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic [2:0]       Funct3E,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  ImmExtE,
    input  logic [XLEN-1:0]  WriteDataE,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic             StallM,
    input  logic             FlushM,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             ValidM,
    output logic [XLEN-1:0]  ALUResultM,
    output logic [XLEN-1:0]  WriteDataM,
    output logic [4:0]       RdM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [XLEN-1:0]  PCPlus4M,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    // Handshake: an EX instruction leaves EX on a cycle where ValidE=1 and
    // StallM=0 (and not in reset); while StallM=1 it waits in EX unchanged.
    logic cond;
    logic adv_e;
    logic branch_inc;
    logic taken_inc;

    branch_cond u_branch_cond (
        .funct3 (Funct3E),
        .z      (ZE),
        .n      (NE),
        .v      (VE),
        .c      (CE),
        .cond   (cond)
    );

    assign adv_e = ValidE & ~StallM & ~rst;

    // Gated by adv_e, so a stalled instruction redirects only on its release cycle.
    assign PCSrcE = adv_e & (JumpE | (BranchE & cond));

    always_comb begin
        PCTargetE = PCE + ImmExtE;
        if (JumpE && JalrE) begin
            PCTargetE = {ALUResultE[XLEN-1:1], 1'b0};
        end
    end

    assign branch_inc = adv_e & BranchE & ~FlushM;
    assign taken_inc  = PCSrcE & ~FlushM;

    always_ff @(posedge clk) begin
        if (rst) begin
            ValidM      <= 1'b0;
            ALUResultM  <= '0;
            WriteDataM  <= '0;
            RdM         <= '0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= RESULT_ALU;
            PCPlus4M    <= '0;
            BranchCount <= '0;
            TakenCount  <= '0;
        end else begin
            // Flush beats stall: the bubble only clears control, data fields hold.
            if (FlushM) begin
                ValidM    <= 1'b0;
                RegWriteM <= 1'b0;
                MemWriteM <= 1'b0;
            end else if (!StallM) begin
                ValidM     <= ValidE;
                ALUResultM <= ALUResultE;
                WriteDataM <= WriteDataE;
                RdM        <= RdE;
                RegWriteM  <= RegWriteE & ValidE;
                MemWriteM  <= MemWriteE & ValidE;
                ResultSrcM <= ResultSrcE;
                PCPlus4M   <= PCPlus4E;
            end
            if (branch_inc) begin
                BranchCount <= BranchCount + 1'b1;
            end
            if (taken_inc) begin
                TakenCount <= TakenCount + 1'b1;
            end
        end
    end

endmodule
